// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared register-file constants and index type for the ID stage
package mycpu_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/mycpu_sb_counter.sv
// rtl/mycpu_sb_counter.sv - per-register pending-write counter with saturation and underflow guard
module mycpu_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             is_zero_o,
    output logic             is_max_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q;
    logic             dec_eff;

    assign is_zero_o   = (count_q == '0);
    assign is_max_o    = (count_q == {CNT_W{1'b1}});
    assign underflow_o = dec_i & is_zero_o;
    assign dec_eff     = dec_i & ~is_zero_o;
    assign count_o     = count_q;
    assign busy_o      = busy_q;

    // A simultaneous retire and new write on the same register cancel out.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_eff && !is_max_o) begin
            count_d = count_q + 1'b1;
        end else if (dec_eff && !inc_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= (count_d != '0);
        end
    end

endmodule

// File: rtl/mycpu_id_scoreboard.sv
// rtl/mycpu_id_scoreboard.sv - ID-stage register scoreboard: hazard detect, issue/stall, stall counter, error flag
module mycpu_id_scoreboard
    import mycpu_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_wen,
    input  logic [REG_AW-1:0]   id_dest,
    input  logic                ex_ready,
    input  logic                flush,
    input  logic                wb_wen,
    input  logic [REG_AW-1:0]   wb_waddr,
    output logic                issue,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [31:0]         stall_cnt,
    output logic                sb_err
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] cnt_zero, cnt_max, cnt_udf;
    logic                inc;
    logic                rs_busy, rt_busy, dest_full, hazard;
    logic                err_set;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic                sb_err_q, sb_err_d;

    // Register 0 is hardwired: never pending, never full, never in error.
    assign cnt[0]       = '0;
    assign cnt_zero[0]  = 1'b1;
    assign cnt_max[0]   = 1'b0;
    assign cnt_udf[0]   = 1'b0;
    assign busy_mask[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        mycpu_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc_i      (inc && (id_dest == reg_idx_t'(i))),
            .dec_i      (wb_wen && (wb_waddr == reg_idx_t'(i))),
            .count_o    (cnt[i]),
            .busy_o     (busy_mask[i]),
            .is_zero_o  (cnt_zero[i]),
            .is_max_o   (cnt_max[i]),
            .underflow_o(cnt_udf[i])
        );
    end

    // The last outstanding write retiring this cycle is forwarded by the register file.
    assign rs_busy = !cnt_zero[id_rs] &&
                     !(WB_BYPASS && wb_wen && (wb_waddr == id_rs) && (cnt[id_rs] == CNT_W'(1)));
    assign rt_busy = !cnt_zero[id_rt] &&
                     !(WB_BYPASS && wb_wen && (wb_waddr == id_rt) && (cnt[id_rt] == CNT_W'(1)));
    assign dest_full = id_wen && (id_dest != REG_ZERO) && cnt_max[id_dest];

    assign hazard = (id_use_rs && rs_busy) || (id_use_rt && rt_busy) || dest_full;
    assign issue  = !rst && id_valid && !flush && !hazard && ex_ready;
    assign stall  = !rst && id_valid && !flush && (hazard || !ex_ready);
    assign inc    = issue && id_wen && (id_dest != REG_ZERO);

    assign err_set = (|cnt_udf) || (inc && cnt_max[id_dest]);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        sb_err_d = sb_err_q | err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_mycpu_id_scoreboard.sv
// tb/tb_mycpu_id_scoreboard.sv - directed scenarios plus randomized run against a queue-based reference model
module tb_mycpu_id_scoreboard;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_wen, ex_ready, flush, wb_wen;
    logic [4:0]  id_rs, id_rt, id_dest, wb_waddr;
    logic        issue, stall, sb_err;
    logic [31:0] busy_mask, stall_cnt;
    logic        issue_nb, stall_nb, sb_err_nb;
    logic [31:0] busy_mask_nb, stall_cnt_nb;

    int tests_run = 0;
    int tests_failed = 0;
    int q[$];

    always #5 clk = ~clk;

    mycpu_id_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen), .id_dest(id_dest),
        .ex_ready(ex_ready), .flush(flush), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .issue(issue), .stall(stall), .busy_mask(busy_mask), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    mycpu_id_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen), .id_dest(id_dest),
        .ex_ready(ex_ready), .flush(flush), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .issue(issue_nb), .stall(stall_nb), .busy_mask(busy_mask_nb), .stall_cnt(stall_cnt_nb),
        .sb_err(sb_err_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wen = 0; flush = 0; wb_wen = 0;
        ex_ready = 1; id_rs = 0; id_rt = 0; id_dest = 0; wb_waddr = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    function automatic int qcount(input int r);
        int n = 0;
        foreach (q[k]) if (q[k] == r) n++;
        return n;
    endfunction

    task automatic test_reset();
        set_idle();
        rst = 1; id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_rs = 3; id_rt = 4;
        #1;
        tests_run++; if (issue !== 1'b0) begin tests_failed++; $display("FAIL reset_issue got=%b exp=0", issue); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tick();
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        tests_run++; if (stall_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
        rst = 0;
        #1;
        tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL reset_first_issue got=%b exp=1", issue); end
        tick();
        set_idle();
    endtask

    task automatic test_raw();
        int first0 = -1, first1 = -1;
        logic [31:0] base0, base1;
        do_reset();
        id_valid = 1; id_wen = 1; id_dest = 5;
        #1;
        tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL raw_producer got=%b exp=1", issue); end
        tick();
        id_wen = 0; id_use_rs = 1; id_rs = 5;
        tests_run++; if (busy_mask[5] !== 1'b1) begin tests_failed++; $display("FAIL raw_busy5 got=%b exp=1", busy_mask[5]); end
        base0 = stall_cnt; base1 = stall_cnt_nb;
        for (int c = 0; c < 6; c++) begin
            wb_wen = (c == 3); wb_waddr = 5;
            #1;
            if (issue && first0 < 0) first0 = c;
            if (issue_nb && first1 < 0) first1 = c;
            tick();
        end
        set_idle();
        tests_run++; if (first0 != 3) begin tests_failed++; $display("FAIL raw_issue_bypass got=%0d exp=3", first0); end
        tests_run++; if (first1 != 4) begin tests_failed++; $display("FAIL raw_issue_nobypass got=%0d exp=4", first1); end
        tests_run++; if (stall_cnt - base0 !== 32'd3) begin tests_failed++; $display("FAIL raw_stalls_bypass got=%0d exp=3", stall_cnt - base0); end
        tests_run++; if (stall_cnt_nb - base1 !== 32'd4) begin tests_failed++; $display("FAIL raw_stalls_nobypass got=%0d exp=4", stall_cnt_nb - base1); end
        tests_run++; if (busy_mask[5] !== 1'b0) begin tests_failed++; $display("FAIL raw_busy5_clear got=%b exp=0", busy_mask[5]); end
    endtask

    task automatic test_waw();
        do_reset();
        id_valid = 1; id_wen = 1; id_dest = 7;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL waw_issue%0d got=%b exp=1", k, issue); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            wb_wen = (k == 1); wb_waddr = 7;
            #1;
            tests_run++; if (stall !== 1'b1 || issue !== 1'b0) begin tests_failed++; $display("FAIL waw_full%0d got=%b%b exp=10", k, stall, issue); end
            tick();
        end
        wb_wen = 0;
        #1;
        tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL waw_fourth got=%b exp=1", issue); end
        tick();
        set_idle();
        tests_run++; if (busy_mask[7] !== 1'b1 || sb_err !== 1'b0) begin tests_failed++; $display("FAIL waw_state got=%b%b exp=10", busy_mask[7], sb_err); end
        wb_wen = 1; wb_waddr = 7;
        repeat (3) tick();
        set_idle();
        tests_run++; if (busy_mask[7] !== 1'b0 || sb_err !== 1'b0) begin tests_failed++; $display("FAIL waw_drain got=%b%b exp=00", busy_mask[7], sb_err); end
    endtask

    task automatic test_same_reg();
        do_reset();
        id_valid = 1; id_wen = 1; id_dest = 9;
        tick();
        wb_wen = 1; wb_waddr = 9;
        #1;
        tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL same_issue got=%b exp=1", issue); end
        tick();
        set_idle();
        tests_run++; if (busy_mask[9] !== 1'b1) begin tests_failed++; $display("FAIL same_busy9 got=%b exp=1", busy_mask[9]); end
        wb_wen = 1; wb_waddr = 9;
        tick();
        set_idle();
        tests_run++; if (busy_mask[9] !== 1'b0 || sb_err !== 1'b0) begin tests_failed++; $display("FAIL same_retire got=%b%b exp=00", busy_mask[9], sb_err); end
    endtask

    task automatic test_r0();
        do_reset();
        id_valid = 1; id_wen = 1; id_dest = 0;
        #1;
        tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL r0_write got=%b exp=1", issue); end
        tick();
        id_wen = 0; id_use_rs = 1; id_use_rt = 1; id_rs = 0; id_rt = 0;
        #1;
        tests_run++; if (issue !== 1'b1 || stall !== 1'b0) begin tests_failed++; $display("FAIL r0_read got=%b%b exp=10", issue, stall); end
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL r0_busy got=%h exp=0", busy_mask); end
        tick();
        set_idle();
    endtask

    task automatic test_err_flush();
        do_reset();
        wb_wen = 1; wb_waddr = 12;
        #1;
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL err_before got=%b exp=0", sb_err); end
        tick();
        set_idle();
        tests_run++; if (sb_err !== 1'b1) begin tests_failed++; $display("FAIL err_set got=%b exp=1", sb_err); end
        tick(); tick();
        tests_run++; if (sb_err !== 1'b1 || busy_mask[12] !== 1'b0) begin tests_failed++; $display("FAIL err_sticky got=%b%b exp=10", sb_err, busy_mask[12]); end
        id_valid = 1; id_wen = 1; id_dest = 3;
        tick();
        id_wen = 0; id_use_rs = 1; id_rs = 3;
        #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_stall got=%b exp=1", stall); end
        flush = 1;
        #1;
        tests_run++; if (issue !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL flush_outputs got=%b%b exp=00", issue, stall); end
        tick();
        set_idle();
        tests_run++; if (busy_mask[3] !== 1'b1) begin tests_failed++; $display("FAIL flush_keeps_count got=%b exp=1", busy_mask[3]); end
        rst = 1;
        tick();
        rst = 0;
        tests_run++; if (busy_mask !== 32'h0 || stall_cnt !== 32'h0 || sb_err !== 1'b0) begin
            tests_failed++; $display("FAIL rst_clear got=%h/%0d/%b exp=0/0/0", busy_mask, stall_cnt, sb_err);
        end
    endtask

    task automatic test_random();
        logic exp_issue, exp_stall, exp_haz, busy_rs, busy_rt;
        logic [31:0] exp_mask;
        int model_stalls = 0;
        int crs, crt;
        logic held = 0;
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!held) begin
                id_valid = ($urandom_range(0, 9) < 8); id_wen = $urandom_range(0, 1);
                id_use_rs = $urandom_range(0, 1); id_use_rt = $urandom_range(0, 1);
                id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
                id_dest = 5'($urandom_range(0, 7));
            end
            ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            wb_waddr = 5'($urandom_range(0, 31));
            wb_wen = 0;
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_wen = 1; wb_waddr = 5'(q[0]);
            end else if ($urandom_range(0, 19) == 0) begin
                wb_wen = 1; wb_waddr = 0;
            end
            crs = qcount(id_rs); crt = qcount(id_rt);
            busy_rs = (crs != 0) && !(wb_wen && wb_waddr == id_rs && crs == 1);
            busy_rt = (crt != 0) && !(wb_wen && wb_waddr == id_rt && crt == 1);
            exp_haz = (id_use_rs && busy_rs) || (id_use_rt && busy_rt) ||
                      (id_wen && id_dest != 0 && qcount(id_dest) == CMAX);
            exp_stall = id_valid && !flush && (exp_haz || !ex_ready);
            exp_issue = id_valid && !flush && !exp_haz && ex_ready;
            for (int r = 0; r < 32; r++) exp_mask[r] = (qcount(r) != 0);
            #1;
            tests_run++; if (issue !== exp_issue) begin tests_failed++; $display("FAIL rnd_issue cyc=%0d got=%b exp=%b", cyc, issue, exp_issue); end
            tests_run++; if (stall !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_stall); end
            tests_run++; if (busy_mask !== exp_mask) begin tests_failed++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy_mask, exp_mask); end
            tests_run++; if (stall_cnt !== 32'(model_stalls)) begin tests_failed++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, model_stalls); end
            tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL rnd_sb_err cyc=%0d got=%b exp=0", cyc, sb_err); end
            if (wb_wen && q.size() > 0 && wb_waddr == 5'(q[0])) void'(q.pop_front());
            if (exp_issue && id_wen && id_dest != 0) q.push_back(int'(id_dest));
            if (exp_stall) model_stalls++;
            held = exp_stall;
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        tick();
        test_reset();
        test_raw();
        test_waw();
        test_same_reg();
        test_r0();
        test_err_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
